// File: rtl/scan_pkg.sv
// Shared state encoding, default sizes and index-width helper for first_match_scanner.
package scan_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_e;

    localparam int unsigned DEFAULT_DEPTH = 8;
    localparam int unsigned DEFAULT_WIDTH = 8;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/first_match_scanner_if.sv
// Request/result handshake bundle for first_match_scanner; master drives requests, slave is the scanner.
interface first_match_scanner_if
    import scan_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    localparam int unsigned IW = idx_w(DEPTH);
    localparam int unsigned VW = idx_w(DEPTH + 1);

    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_key;
    logic [DEPTH*WIDTH-1:0] in_data;
    logic [DEPTH-1:0]       in_skip;
    logic                   abort;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_found;
    logic [IW-1:0]          out_index;
    logic [VW-1:0]          out_visited;

    modport master (
        output in_valid, in_key, in_data, in_skip, abort, out_ready,
        input  in_ready, out_valid, out_found, out_index, out_visited
    );

    modport slave (
        input  in_valid, in_key, in_data, in_skip, abort, out_ready,
        output in_ready, out_valid, out_found, out_index, out_visited
    );

endinterface

// File: rtl/scan_entry_sel.sv
// Selects the latched entry and skip bit at the scan index and compares the entry with the key.
module scan_entry_sel
    import scan_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned IW    = idx_w(DEPTH)
) (
    input  logic [DEPTH*WIDTH-1:0] i_data,
    input  logic [DEPTH-1:0]       i_skip,
    input  logic [WIDTH-1:0]       i_key,
    input  logic [IW-1:0]          i_idx,
    output logic                   o_skip,
    output logic                   o_match
);

    logic [WIDTH-1:0] w_entries [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        assign w_entries[g] = i_data[g*WIDTH +: WIDTH];
    end

    assign o_skip  = i_skip[i_idx];
    assign o_match = (w_entries[i_idx] == i_key);

endmodule

// File: rtl/first_match_scanner.sv
// Sequential first-match key scanner: one entry per clock, skip mask, early exit on first match.
// Optional mid-scan cancel via the abort input when SCAN_ABORT_EN is defined.
module first_match_scanner
    import scan_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    first_match_scanner_if.slave io_bus
);

    localparam int unsigned   IW       = idx_w(DEPTH);
    localparam int unsigned   VW       = idx_w(DEPTH + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    scan_state_e            r_state;
    logic [WIDTH-1:0]       r_key;
    logic [DEPTH*WIDTH-1:0] r_data;
    logic [DEPTH-1:0]       r_skip;
    logic [IW-1:0]          r_idx;
    logic [IW-1:0]          r_index;
    logic [VW-1:0]          r_visited;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic                   r_found;

    logic w_skip;
    logic w_match;
    logic w_abort;

`ifdef SCAN_ABORT_EN
    assign w_abort = io_bus.abort;
`else
    // Port kept for pin compatibility; it never influences the scan.
    assign w_abort = io_bus.abort & 1'b0;
`endif

    scan_entry_sel #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_entry_sel (
        .i_data  (r_data),
        .i_skip  (r_skip),
        .i_key   (r_key),
        .i_idx   (r_idx),
        .o_skip  (w_skip),
        .o_match (w_match)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_key       <= '0;
            r_data      <= '0;
            r_skip      <= '0;
            r_idx       <= '0;
            r_index     <= '0;
            r_visited   <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_found     <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (io_bus.in_valid) begin
                        r_key      <= io_bus.in_key;
                        r_data     <= io_bus.in_data;
                        r_skip     <= io_bus.in_skip;
                        r_idx      <= '0;
                        r_visited  <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_abort) begin
                        // Cancel before comparing the current entry.
                        r_found     <= 1'b0;
                        r_index     <= r_idx;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        if (!w_skip) begin
                            r_visited <= r_visited + VW'(1);
                        end
                        if (!w_skip && w_match) begin
                            r_found     <= 1'b1;
                            r_index     <= r_idx;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else if (r_idx == LAST_IDX) begin
                            r_found     <= 1'b0;
                            r_index     <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
                DONE: begin
                    if (io_bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_bus.in_ready    = r_in_ready;
    assign io_bus.out_valid   = r_out_valid;
    assign io_bus.out_found   = r_found;
    assign io_bus.out_index   = r_index;
    assign io_bus.out_visited = r_visited;

endmodule

// File: tb/tb_first_match_scanner.sv
// Scoreboard bench for first_match_scanner: directed cases plus randomized requests vs a reference model.
module tb_first_match_scanner;
    import scan_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned IW    = idx_w(DEPTH);
    localparam int unsigned VW    = idx_w(DEPTH + 1);
`ifdef SCAN_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    typedef struct {
        int found;
        int index;
        int visited;
        int lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_errors;
    bit   hold_ready;
    exp_t sb[$];

    first_match_scanner_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    first_match_scanner #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: walk entries in order, honour skip, stop at first equal entry or at abort.
    function automatic exp_t model(input logic [WIDTH-1:0] key,
                                   input logic [DEPTH*WIDTH-1:0] data,
                                   input logic [DEPTH-1:0] skip, input int abort_at);
        exp_t e;
        int   vis = 0;
        e.found = 0;
        e.index = 0;
        e.lat   = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin
            if (ABORT_EN && i == abort_at) begin
                e.index = i;
                e.lat   = i + 1;
                break;
            end
            if (skip[i]) continue;
            vis++;
            if (data[i*WIDTH +: WIDTH] == key) begin
                e.found = 1;
                e.index = i;
                e.lat   = i + 1;
                break;
            end
        end
        e.visited = vis;
        return e;
    endfunction

    function automatic logic [DEPTH*WIDTH-1:0] rand_data();
        logic [DEPTH*WIDTH-1:0] d;
        for (int i = 0; i < DEPTH; i++) d[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 3));
        return d;
    endfunction

    function automatic logic [DEPTH*WIDTH-1:0] one_hit(input int pos, input logic [WIDTH-1:0] v);
        logic [DEPTH*WIDTH-1:0] d = '0;
        d[pos*WIDTH +: WIDTH] = v;
        return d;
    endfunction

    task automatic issue(input logic [WIDTH-1:0] key, input logic [DEPTH*WIDTH-1:0] data,
                         input logic [DEPTH-1:0] skip, input int abort_at);
        int guard = 0;
        @(posedge clk); #1;
        while (!bus.in_ready && guard < 200) begin
            // Junk requests while busy must be ignored.
            bus.in_valid = ($urandom_range(0, 1) == 1);
            bus.in_key   = WIDTH'($urandom);
            bus.in_data  = rand_data();
            bus.in_skip  = DEPTH'($urandom);
            @(posedge clk); #1;
            guard++;
        end
        if (!bus.in_ready) begin
            bus.in_valid = 1'b0;
            check("in_ready_timeout", bus.in_ready, 1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_key   = key;
        bus.in_data  = data;
        bus.in_skip  = skip;
        sb.push_back(model(key, data, skip, abort_at));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (abort_at >= 0) begin
            repeat (abort_at) begin
                @(posedge clk); #1;
            end
            bus.abort = 1'b1;
            @(posedge clk); #1;
            bus.abort = 1'b0;
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    // Result-side handshake driver.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: sample at the falling edge, pop the scoreboard on each result handshake.
    initial begin
        int             acc_cyc = 0;
        bit             prev_valid = 0;
        bit             release_chk = 0;
        logic           h_found = 0;
        logic [IW-1:0]  h_index = '0;
        logic [VW-1:0]  h_visited = '0;
        exp_t           e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid  = 0;
                release_chk = 0;
            end else begin
                if (release_chk) begin
                    check("release_in_ready", bus.in_ready, 1);
                    check("release_out_valid", bus.out_valid, 0);
                    release_chk = 0;
                end
                if (bus.in_valid && bus.in_ready) acc_cyc = cyc;
                if (bus.out_valid) begin
                    check("busy_in_ready", bus.in_ready, 0);
                    if (!prev_valid) begin
                        if (sb.size() == 0) check("result_without_request", sb.size(), 1);
                        else check("latency", cyc - acc_cyc - 1, sb[0].lat);
                    end else begin
                        check("stable_found", bus.out_found, h_found);
                        check("stable_index", bus.out_index, h_index);
                        check("stable_visited", bus.out_visited, h_visited);
                    end
                    h_found   = bus.out_found;
                    h_index   = bus.out_index;
                    h_visited = bus.out_visited;
                    if (bus.out_ready) begin
                        if (sb.size() != 0) begin
                            e = sb.pop_front();
                            check("found", bus.out_found, e.found);
                            check("index", bus.out_index, e.index);
                            check("visited", bus.out_visited, e.visited);
                        end
                        release_chk = 1;
                        prev_valid  = 0;
                    end else begin
                        prev_valid = 1;
                    end
                end else begin
                    prev_valid = 0;
                end
            end
        end
    end

    initial begin
        logic [DEPTH*WIDTH-1:0] d;
        int guard;
        n_checks     = 0;
        n_errors     = 0;
        hold_ready   = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_key   = '0;
        bus.in_data  = '0;
        bus.in_skip  = '0;
        bus.abort    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_found", bus.out_found, 0);
        check("rst_index", bus.out_index, 0);
        check("rst_visited", bus.out_visited, 0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(8'h5A, one_hit(3, 8'h5A), 8'h00, -1);
        issue(8'h5A, one_hit(1, 8'h5A) | one_hit(3, 8'h5A), 8'h02, -1);
        issue(8'h5A, '0, 8'h81, -1);
        issue(8'h5A, one_hit(6, 8'h5A), 8'h00, 2);
        issue(8'h5A, one_hit(2, 8'h5A), 8'hFF, -1);
        issue(8'h5A, one_hit(7, 8'h5A), 8'h00, -1);
        issue(8'h11, one_hit(0, 8'h11), 8'h00, -1);

        // Result held back in DONE for five cycles.
        drain();
        hold_ready = 1;
        issue(8'h33, one_hit(2, 8'h33), 8'h00, -1);
        guard = 0;
        while (!bus.out_valid && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (5) begin
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_in_ready", bus.in_ready, 0);
            @(posedge clk); #1;
        end
        hold_ready = 0;
        drain();

        // Reset while entry 4 is being examined.
        issue(8'h5A, '0, 8'h00, -1);
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", bus.out_valid, 0);
        check("midreset_in_ready", bus.in_ready, 1);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'h5A, one_hit(0, 8'h5A) | one_hit(5, 8'h5A), 8'h00, -1);

        for (int n = 0; n < 150; n++) begin
            d = rand_data();
            issue(WIDTH'($urandom_range(0, 3)), d, DEPTH'($urandom & $urandom),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1)) : -1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
